// File: rtl/pwm_sample_sequencer.sv
// Sample FIFO and playback sequencer that feeds duty values to a PWM.
// Define PWM_SEQ_UNDERRUN_COUNT_EN to enable the saturating underrun counter.
module pwm_sample_sequencer #(
   parameter int SAMPLE_WIDTH = 8,
   parameter int FIFO_DEPTH   = 16,
   parameter int PRIME_LEVEL  = 8
) (
   input  logic                          Clock,
   input  logic                          Reset,
   input  logic                          Start,
   input  logic                          Stop,
   input  logic [SAMPLE_WIDTH-1:0]       SampleIn,
   input  logic                          SampleValid,
   output logic                          SampleReady,
   input  logic                          PeriodEnd,
   output logic [SAMPLE_WIDTH-1:0]       Duty,
   output logic                          Playing,
   output logic                          Underrun,
   output logic [$clog2(FIFO_DEPTH):0]   FifoLevel,
   output logic [15:0]                   UnderrunCount
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_LVL  = FIFO_DEPTH[AW:0];
   localparam logic [AW:0] PRIME_LVL = PRIME_LEVEL[AW:0];
   localparam logic [SAMPLE_WIDTH-1:0] MID =
      {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      PLAY,
      DRAIN
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic empty;
   logic full;
   logic push;
   logic pop;
   logic underrun_ev;
   logic drain_done;

   assign empty = (FifoLevel == '0);
   assign full  = (FifoLevel == FULL_LVL);

   // Room is judged on the registered level only; a same-cycle pop does not free a slot.
   assign SampleReady = !full && !Reset;
   assign push = SampleValid && SampleReady;

   always_ff @(posedge Clock) begin
      if (Reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (Start && !Stop)
               state_nxt = PRIME;
         end
         PRIME: begin
            if (Stop)
               state_nxt = IDLE;
            else if (FifoLevel >= PRIME_LVL)
               state_nxt = PLAY;
         end
         PLAY: begin
            if (Stop)
               state_nxt = DRAIN;
            else if (PeriodEnd && empty)
               state_nxt = PRIME;
         end
         DRAIN: begin
            if (PeriodEnd && empty)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      Playing     = 1'b0;
      pop         = 1'b0;
      underrun_ev = 1'b0;
      drain_done  = 1'b0;
      unique case (state)
         PLAY: begin
            Playing     = 1'b1;
            pop         = PeriodEnd && !empty;
            underrun_ev = PeriodEnd && empty && !Stop;
         end
         DRAIN: begin
            Playing    = 1'b1;
            pop        = PeriodEnd && !empty;
            drain_done = PeriodEnd && empty;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (push)
         mem[wptr] <= SampleIn;
   end

   // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH on their own.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         wptr      <= '0;
         rptr      <= '0;
         FifoLevel <= '0;
         Duty      <= '0;
         Underrun  <= 1'b0;
      end else begin
         Underrun <= underrun_ev;
         if (push)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         if (push && !pop)
            FifoLevel <= FifoLevel + 1'b1;
         else if (!push && pop)
            FifoLevel <= FifoLevel - 1'b1;
         if (pop)
            Duty <= mem[rptr];
         else if (underrun_ev)
            Duty <= MID;
         else if (drain_done)
            Duty <= '0;
      end
   end

`ifdef PWM_SEQ_UNDERRUN_COUNT_EN
   logic [15:0] ucnt;

   always_ff @(posedge Clock) begin
      if (Reset)
         ucnt <= '0;
      else if (underrun_ev && ucnt != 16'hFFFF)
         ucnt <= ucnt + 16'd1;
   end

   assign UnderrunCount = ucnt;
`else
   assign UnderrunCount = '0;
`endif

endmodule

// File: tb/tb_pwm_sample_sequencer.sv
// Bench for pwm_sample_sequencer: directed scenarios plus random
// traffic against a queue-based playback model.
module tb_pwm_sample_sequencer;

   localparam int SW    = 8;
   localparam int DEPTH = 16;
   localparam int PL    = 8;

   localparam int M_IDLE  = 0;
   localparam int M_PRIME = 1;
   localparam int M_PLAY  = 2;
   localparam int M_DRAIN = 3;

`ifdef PWM_SEQ_UNDERRUN_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic          Start = 1'b0;
   logic          Stop = 1'b0;
   logic [SW-1:0] SampleIn = '0;
   logic          SampleValid = 1'b0;
   logic          SampleReady;
   logic          PeriodEnd = 1'b0;
   logic [SW-1:0] Duty;
   logic          Playing;
   logic          Underrun;
   logic [4:0]    FifoLevel;
   logic [15:0]   UnderrunCount;

   int checks = 0;
   int errors = 0;

   logic [SW-1:0] q[$];
   int            mst = M_IDLE;
   logic [SW-1:0] mduty = '0;
   logic          munder = 1'b0;
   int            mcount = 0;

   pwm_sample_sequencer #(
      .SAMPLE_WIDTH(SW),
      .FIFO_DEPTH(DEPTH),
      .PRIME_LEVEL(PL)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .Start(Start),
      .Stop(Stop),
      .SampleIn(SampleIn),
      .SampleValid(SampleValid),
      .SampleReady(SampleReady),
      .PeriodEnd(PeriodEnd),
      .Duty(Duty),
      .Playing(Playing),
      .Underrun(Underrun),
      .FifoLevel(FifoLevel),
      .UnderrunCount(UnderrunCount)
   );

   always #5 Clock = ~Clock;

   function automatic void model_step();
      int n;
      bit do_push;
      n = q.size();
      if (Reset) begin
         q.delete();
         mst    = M_IDLE;
         mduty  = '0;
         munder = 1'b0;
         mcount = 0;
         return;
      end
      do_push = SampleValid && (n < DEPTH);
      munder = 1'b0;
      case (mst)
         M_IDLE: if (Start && !Stop) mst = M_PRIME;
         M_PRIME: begin
            if (Stop) mst = M_IDLE;
            else if (n >= PL) mst = M_PLAY;
         end
         M_PLAY: begin
            if (PeriodEnd && n > 0) mduty = q.pop_front();
            if (Stop) mst = M_DRAIN;
            else if (PeriodEnd && n == 0) begin
               mst    = M_PRIME;
               mduty  = 8'h80;
               munder = 1'b1;
               if (CNT_EN && mcount < 65535) mcount++;
            end
         end
         default: begin
            if (PeriodEnd && n > 0) mduty = q.pop_front();
            else if (PeriodEnd) begin
               mst   = M_IDLE;
               mduty = '0;
            end
         end
      endcase
      if (do_push) q.push_back(SampleIn);
   endfunction

   task automatic tick();
      @(posedge Clock);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      Start = 0; Stop = 0; SampleValid = 0; PeriodEnd = 0;
      Reset = 1;
      tick();
      Reset = 0;
   endtask

   task automatic push_one(input logic [SW-1:0] v);
      SampleValid = 1;
      SampleIn = v;
      tick();
      SampleValid = 0;
   endtask

   task automatic pulse_pe();
      PeriodEnd = 1;
      tick();
      PeriodEnd = 0;
   endtask

   task automatic start_pulse();
      Start = 1;
      tick();
      Start = 0;
   endtask

   task automatic test_reset();
      Reset = 1;
      SampleValid = 1;
      tick();
      tick();
      checks++;
      if (Duty !== 8'h00) begin errors++; $display("FAIL rst_duty: got %h want 00", Duty); end
      checks++;
      if (Playing !== 1'b0) begin errors++; $display("FAIL rst_playing: got %b want 0", Playing); end
      checks++;
      if (Underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b want 0", Underrun); end
      checks++;
      if (FifoLevel !== 5'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", FifoLevel); end
      checks++;
      if (UnderrunCount !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", UnderrunCount); end
      checks++;
      if (SampleReady !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", SampleReady); end
      Reset = 0;
      SampleValid = 0;
      #1;
      checks++;
      if (SampleReady !== 1'b1) begin errors++; $display("FAIL rst_ready_rel: got %b want 1", SampleReady); end
      tick();
   endtask

   task automatic test_prime_play();
      do_reset();
      start_pulse();
      for (int i = 0; i < 8; i++) push_one(8'(8'h10 + i));
      checks++;
      if (FifoLevel !== 5'd8) begin errors++; $display("FAIL pp_level: got %0d want 8", FifoLevel); end
      checks++;
      if (Playing !== 1'b0) begin errors++; $display("FAIL pp_prime: got %b want 0", Playing); end
      tick();
      checks++;
      if (Playing !== 1'b1) begin errors++; $display("FAIL pp_play: got %b want 1", Playing); end
      for (int k = 0; k < 8; k++) begin
         pulse_pe();
         checks++;
         if (Duty !== 8'(8'h10 + k)) begin
            errors++; $display("FAIL pp_duty%0d: got %h want %h", k, Duty, 8'(8'h10 + k));
         end
         tick();
         checks++;
         if (Duty !== 8'(8'h10 + k)) begin
            errors++; $display("FAIL pp_hold%0d: got %h want %h", k, Duty, 8'(8'h10 + k));
         end
      end
   endtask

   task automatic test_underrun();
      do_reset();
      start_pulse();
      for (int i = 0; i < 7; i++) push_one(8'($urandom));
      push_one(8'h40);
      tick();
      for (int i = 0; i < 7; i++) pulse_pe();
      pulse_pe();
      checks++;
      if (Duty !== 8'h40) begin errors++; $display("FAIL ur_last: got %h want 40", Duty); end
      checks++;
      if (Underrun !== 1'b0) begin errors++; $display("FAIL ur_early: got %b want 0", Underrun); end
      pulse_pe();
      checks++;
      if (Duty !== 8'h80) begin errors++; $display("FAIL ur_mid: got %h want 80", Duty); end
      checks++;
      if (Underrun !== 1'b1) begin errors++; $display("FAIL ur_pulse: got %b want 1", Underrun); end
      checks++;
      if (Playing !== 1'b0) begin errors++; $display("FAIL ur_prime: got %b want 0", Playing); end
      checks++;
      if (UnderrunCount !== 16'(mcount)) begin
         errors++; $display("FAIL ur_count: got %0d want %0d", UnderrunCount, mcount);
      end
      tick();
      checks++;
      if (Underrun !== 1'b0) begin errors++; $display("FAIL ur_width: got %b want 0", Underrun); end
   endtask

   task automatic test_backpressure();
      do_reset();
      start_pulse();
      SampleValid = 1;
      repeat (20) begin
         SampleIn = 8'($urandom);
         tick();
      end
      checks++;
      if (FifoLevel !== 5'd16) begin errors++; $display("FAIL bp_full: got %0d want 16", FifoLevel); end
      checks++;
      if (SampleReady !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", SampleReady); end
      PeriodEnd = 1;
      tick();
      PeriodEnd = 0;
      checks++;
      if (FifoLevel !== 5'd15) begin errors++; $display("FAIL bp_nopush: got %0d want 15", FifoLevel); end
      checks++;
      if (SampleReady !== 1'b1) begin errors++; $display("FAIL bp_room: got %b want 1", SampleReady); end
      tick();
      SampleValid = 0;
      checks++;
      if (FifoLevel !== 5'd16) begin errors++; $display("FAIL bp_refill: got %0d want 16", FifoLevel); end
      for (int i = 0; i < 16; i++) begin
         pulse_pe();
         checks++;
         if (Duty !== mduty) begin errors++; $display("FAIL bp_order%0d: got %h want %h", i, Duty, mduty); end
      end
   endtask

   task automatic test_stop_drain();
      do_reset();
      start_pulse();
      for (int i = 0; i < 8; i++) push_one(8'($urandom));
      tick();
      for (int i = 0; i < 4; i++) pulse_pe();
      PeriodEnd = 1;
      Stop = 1;
      tick();
      PeriodEnd = 0;
      Stop = 0;
      checks++;
      if (Duty !== mduty) begin errors++; $display("FAIL sd_stoppop: got %h want %h", Duty, mduty); end
      checks++;
      if (FifoLevel !== 5'd3) begin errors++; $display("FAIL sd_level: got %0d want 3", FifoLevel); end
      for (int i = 0; i < 3; i++) begin
         pulse_pe();
         checks++;
         if (Duty !== mduty || Playing !== 1'b1) begin
            errors++; $display("FAIL sd_pop%0d: got %h/%b want %h/1", i, Duty, Playing, mduty);
         end
      end
      pulse_pe();
      checks++;
      if (Playing !== 1'b0 || Duty !== 8'h00 || Underrun !== 1'b0) begin
         errors++; $display("FAIL sd_end: got p%b d%h u%b want p0 d00 u0", Playing, Duty, Underrun);
      end
   endtask

   task automatic test_reset_midplay();
      logic [SW-1:0] exp [16];
      do_reset();
      start_pulse();
      for (int i = 0; i < 8; i++) push_one(8'($urandom));
      tick();
      for (int i = 0; i < 3; i++) pulse_pe();
      checks++;
      if (FifoLevel !== 5'd5) begin errors++; $display("FAIL rm_level: got %0d want 5", FifoLevel); end
      Reset = 1;
      SampleValid = 1;
      SampleIn = 8'($urandom);
      #1;
      checks++;
      if (SampleReady !== 1'b0) begin errors++; $display("FAIL rm_ready: got %b want 0", SampleReady); end
      tick();
      Reset = 0;
      SampleValid = 0;
      checks++;
      if (Playing !== 1'b0 || FifoLevel !== 5'd0 || Duty !== 8'h00) begin
         errors++; $display("FAIL rm_clear: got p%b l%0d d%h want p0 l0 d00", Playing, FifoLevel, Duty);
      end
      for (int i = 0; i < 16; i++) begin
         exp[i] = 8'($urandom);
         push_one(exp[i]);
      end
      checks++;
      if (FifoLevel !== 5'd16) begin errors++; $display("FAIL rm_fill: got %0d want 16", FifoLevel); end
      start_pulse();
      tick();
      for (int i = 0; i < 16; i++) begin
         pulse_pe();
         checks++;
         if (Duty !== exp[i]) begin errors++; $display("FAIL rm_wrap%0d: got %h want %h", i, Duty, exp[i]); end
      end
   endtask

   task automatic test_start_stop_idle();
      do_reset();
      Start = 1;
      Stop = 1;
      tick();
      Start = 0;
      Stop = 0;
      for (int i = 0; i < 8; i++) push_one(8'($urandom));
      tick();
      tick();
      checks++;
      if (Playing !== 1'b0) begin errors++; $display("FAIL ss_idle: got %b want 0", Playing); end
      checks++;
      if (FifoLevel !== 5'd8) begin errors++; $display("FAIL ss_level: got %0d want 8", FifoLevel); end
   endtask

   task automatic test_random();
      bit mplay;
      do_reset();
      repeat (3000) begin
         Start       = ($urandom % 12) == 0;
         Stop        = ($urandom % 40) == 0;
         SampleValid = ($urandom % 2) == 0;
         SampleIn    = 8'($urandom);
         PeriodEnd   = ($urandom % 3) == 0;
         Reset       = ($urandom % 400) == 0;
         #1;
         checks++;
         if (SampleReady !== (!Reset && q.size() < DEPTH)) begin
            errors++; $display("FAIL rnd_ready: got %b want %b", SampleReady, (!Reset && q.size() < DEPTH));
         end
         tick();
         mplay = (mst == M_PLAY) || (mst == M_DRAIN);
         checks++;
         if (Duty !== mduty) begin errors++; $display("FAIL rnd_duty: got %h want %h", Duty, mduty); end
         checks++;
         if (Playing !== mplay) begin errors++; $display("FAIL rnd_playing: got %b want %b", Playing, mplay); end
         checks++;
         if (Underrun !== munder) begin errors++; $display("FAIL rnd_underrun: got %b want %b", Underrun, munder); end
         checks++;
         if (FifoLevel !== 5'(q.size())) begin
            errors++; $display("FAIL rnd_level: got %0d want %0d", FifoLevel, q.size());
         end
         checks++;
         if (UnderrunCount !== 16'(mcount)) begin
            errors++; $display("FAIL rnd_count: got %0d want %0d", UnderrunCount, mcount);
         end
      end
      Start = 0; Stop = 0; SampleValid = 0; PeriodEnd = 0; Reset = 0;
   endtask

   initial begin
      test_reset();
      test_prime_play();
      test_underrun();
      test_backpressure();
      test_stop_drain();
      test_reset_midplay();
      test_start_stop_idle();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_sample_sequencer.md
PWM_SAMPLE_SEQUENCER -- requirements
Module: pwm_sample_sequencer

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 8: sample width, matching the PWM duty width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: sample buffer depth; must be a power of two, at least 4.
REQ-003 SHALL have parameter PRIME_LEVEL, default 8: buffer level needed before playback starts; valid range 1..FIFO_DEPTH.
REQ-004 SHALL have port Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port Start, input, 1 bit: single-cycle pulse that requests playback.
REQ-007 SHALL have port Stop, input, 1 bit: single-cycle pulse that ends playback.
REQ-008 SHALL have port SampleIn, input, SAMPLE_WIDTH bits: upstream sample data.
REQ-009 SHALL have port SampleValid, input, 1 bit: upstream data is valid.
REQ-010 SHALL have port SampleReady, output, 1 bit: the sequencer accepts a sample this cycle.
REQ-011 SHALL have port PeriodEnd, input, 1 bit: PWM period-boundary strobe, driven by the PWM EnableOut.
REQ-012 SHALL have port Duty, output, SAMPLE_WIDTH bits, registered: duty value driven into the PWM Switch input.
REQ-013 SHALL have port Playing, output, 1 bit: high when state is PLAY or DRAIN.
REQ-014 SHALL have port Underrun, output, 1 bit: one-cycle pulse on each underrun event.
REQ-015 SHALL have port FifoLevel, output, clog2(FIFO_DEPTH)+1 bits: number of samples currently buffered.
REQ-016 SHALL have port UnderrunCount, output, 16 bits: underrun event count (see Configuration).

Function
REQ-017 SHALL implement a FIFO of FIFO_DEPTH entries; a push occurs when SampleValid and SampleReady are both high.
REQ-018 SHALL drive SampleReady = !full, with full taken from the registered level; a pop in the same cycle does not make room for a push in that cycle.
REQ-019 SHALL implement states IDLE, PRIME, PLAY and DRAIN; reset state is IDLE.
REQ-020 SHALL make these transitions from IDLE: Start goes to PRIME; otherwise stay.
REQ-021 SHALL make these transitions from PRIME: if level >= PRIME_LEVEL, go to PLAY the next cycle; Stop goes to IDLE and the FIFO contents are kept.
REQ-022 SHALL make these transitions from PLAY: Stop goes to DRAIN; PeriodEnd with an empty FIFO goes to PRIME, sets Duty to the midscale value 2^(SAMPLE_WIDTH-1) and pulses Underrun.
REQ-023 SHALL make these transitions from DRAIN: PeriodEnd with an empty FIFO goes to IDLE with Duty set to 0 and no Underrun pulse.
REQ-024 SHALL pop the FIFO head into Duty on PeriodEnd in PLAY or DRAIN when the FIFO is non-empty, with Duty valid the cycle after PeriodEnd (latency 1).
REQ-025 SHALL hold Duty between PeriodEnd strobes; PeriodEnd in IDLE or PRIME pops nothing, and Duty holds its value.
REQ-026 SHALL give Stop priority when Start and Stop occur in the same cycle; Start outside IDLE is ignored.
REQ-027 SHALL keep FifoLevel unchanged on a simultaneous push and pop, and make it exact after every cycle.
REQ-028 SHALL wrap the FIFO pointers modulo FIFO_DEPTH with no data corruption.
REQ-029 SHALL let Stop arriving in the same cycle as PeriodEnd in PLAY take the pop first, then go to DRAIN.
REQ-030 SHALL ignore PeriodEnd pulses that arrive on back-to-back cycles beyond the rules above, with no extra state.

Reset
REQ-031 SHALL, on Reset, set state to IDLE, empty the FIFO with both pointers at 0, and drive Duty=0, Playing=0, Underrun=0, FifoLevel=0 and UnderrunCount=0.
REQ-032 SHALL, on Reset asserted mid-playback, reach the reset values on the next edge; any sample presented during Reset is discarded.
REQ-033 SHALL drive SampleReady low while Reset is high.

Configuration
REQ-034 SHALL, with macro PWM_SEQ_UNDERRUN_COUNT_EN defined, increment UnderrunCount on each Underrun pulse, saturating at 16'hFFFF; only Reset clears it.
REQ-035 SHALL, without PWM_SEQ_UNDERRUN_COUNT_EN, tie UnderrunCount to 0 and include no counter logic.

Verification
REQ-036 SHALL cover prime and play: push 8 samples 0x10..0x17, pulse Start -> PLAY one cycle after level reaches 8; on successive PeriodEnd strobes Duty = 0x10, 0x11, ... each one cycle after the strobe.
REQ-037 SHALL cover underrun: in PLAY with 1 sample 0x40, give 2 PeriodEnd strobes -> Duty=0x40, then Duty=0x80 with a 1-cycle Underrun pulse, state PRIME and UnderrunCount=1 when the macro is defined.
REQ-038 SHALL cover full back-pressure: hold SampleValid in PRIME with no PeriodEnd -> level 16 and SampleReady=0; a pop in the same cycle gives no push that cycle.
REQ-039 SHALL cover Stop and drain: Stop in PLAY with 3 samples buffered -> 3 pops on the next 3 PeriodEnd strobes, then the 4th strobe gives IDLE, Duty=0 and no Underrun pulse.
REQ-040 SHALL cover Reset mid-play: assert Reset with level 5 in PLAY -> next edge gives IDLE, FifoLevel=0, Duty=0; after release, push 16 samples without corruption to confirm pointer wrap.
REQ-041 SHALL cover Start and Stop in the same cycle in IDLE -> remains in IDLE.
